instr_dispatch_scheduler: RTL and testbench
===========================================

Name: instr_dispatch_scheduler

Overview:
- Buffers custom-instruction words (dataA/dataB) from the processor in a FIFO and dispatches them one at a time to the video datapath (decoder/control unit).
- Memory-write opcodes are held back until the print module reports it is not scanning sprite memory.
- Tracks completion of each dispatched instruction through a done handshake, with a timeout watchdog.
- Sits between the processor custom-instruction interface and decorderInstruction/controlUnit, on clk_100.

Parameters:
DEPTH, 8, FIFO entries; must be a power of 2.
PTR_BITS, 3, log2(DEPTH).
MEM_OPCODE, 4'b0001, opcode (dataA[3:0]) that requires a blanking window.
TIMEOUT, 255, maximum cycles spent in WAIT_DONE before abort; range 1..255.

Ports:
clk  in  1  datapath clock (100 MHz domain)
reset  in  1  asynchronous, active-high; clears all state
clk_en  in  1  push request; one instruction per cycle high
dataA  in  32  instruction word A; [3:0] is the opcode
dataB  in  32  instruction word B
printtingScreen  in  1  1 = print module is reading sprite memory
done  in  1  one-cycle completion pulse from the datapath
out_dataA  out  32  dispatched word A (registered, stable from ISSUE until the next load)
out_dataB  out  32  dispatched word B
issue  out  1  one-cycle pulse; out_data valid
busy  out  1  high in any state other than IDLE
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  PTR_BITS+1  current occupancy
overflow  out  1  sticky; a push was dropped while full
timeout_err  out  1  sticky; a dispatch timed out

Behaviour:
- Reset values (asynchronous):
  - state = IDLE.
  - wr_ptr, rd_ptr, count and the timer = 0.
  - out_dataA, out_dataB, issue, busy, full, overflow and timeout_err = 0.
  - empty = 1.
- Push: on a clk edge with clk_en=1 and full=0, write {dataA, dataB} at wr_ptr, then wr_ptr+1, wrapping modulo DEPTH.
  - If clk_en=1 while full=1, the word is dropped, overflow is set and the FIFO is unchanged.
  - full is evaluated on pre-edge state, so a pop in the same cycle does not admit the push.
- Pop: happens only in IDLE when empty=0. The head is loaded into out_dataA/out_dataB, rd_ptr+1 wraps.
- Count update on simultaneous push and pop (not full): count is unchanged. Otherwise count = count + push - pop.
- full, empty and count are registered and reflect post-edge state.
- FSM:
  - IDLE: if empty=0, pop and go to WAIT_WINDOW. Otherwise stay.
  - WAIT_WINDOW: if out_dataA[3:0]==MEM_OPCODE and printtingScreen=1, stay. Otherwise go to ISSUE.
  - ISSUE: issue=1 for exactly this cycle; clear the timer; go to WAIT_DONE.
  - WAIT_DONE:
    - If done=1, go to IDLE.
    - Else if timer==TIMEOUT-1, set timeout_err and go to IDLE (the instruction is abandoned).
    - Else timer+1.
- done sampled in IDLE, WAIT_WINDOW or ISSUE is ignored; it is never latched.
- done and the timeout condition in the same cycle: done wins, timeout_err is not set.
- Latency: a push at edge 0 into an empty FIFO, with the window open, gives issue=1 in the cycle after edge 2. The next instruction needs at least 3 further cycles after done.
- printtingScreen is asynchronous to clk and is passed through a 2-flop synchronizer inside the block, which adds 2 cycles of window latency.
- overflow and timeout_err clear only on reset.
- Reset mid-operation: the FIFO contents are discarded, the FSM returns to IDLE, and any pending dispatch is lost with no issue pulse.
- Pointer arithmetic is PTR_BITS wide and wraps naturally; count is PTR_BITS+1 wide so it can hold DEPTH.

Test Plan:
- Reset, then push dataA=32'h3fff1, dataB=12 (non-memory opcode), with done returned 3 cycles after issue -> issue pulses once in the cycle after edge 2, out_dataA=32'h3fff1, busy falls 1 cycle after done, empty=1.
- Push dataA[3:0]=4'b0001 with printtingScreen held 1 for 50 cycles, then 0 -> no issue while printtingScreen=1; issue occurs 3 cycles after the fall (2 synchronizer + 1).
- Push 9 words back-to-back with no pops (FSM stalled in WAIT_WINDOW on a memory opcode) -> 1 word popped; count reaches 8, full=1; the 9th word is dropped and overflow=1 and stays 1.
- TIMEOUT=4, dispatch with done never asserted -> timeout_err=1 after 4 WAIT_DONE cycles, FSM back in IDLE; the next queued word then issues normally.
- done asserted in the same cycle as the timeout edge -> timeout_err stays 0. A stray done in IDLE has no effect on the next dispatch.
- Assert reset while in WAIT_DONE with 3 words queued -> all outputs return to their reset values immediately; no issue pulse after release until a new push.

Source files
------------

// File: rtl/instr_dispatch_scheduler_if.sv
// instr_dispatch_scheduler_if: processor-side push bus plus datapath dispatch/done handshake
interface instr_dispatch_scheduler_if #(
    parameter int PTR_BITS = 3
);
    logic                clk_en;
    logic [31:0]         dataA;
    logic [31:0]         dataB;
    logic                printtingScreen;
    logic                done;
    logic [31:0]         out_dataA;
    logic [31:0]         out_dataB;
    logic                issue;
    logic                busy;
    logic                full;
    logic                empty;
    logic [PTR_BITS:0]   count;
    logic                overflow;
    logic                timeout_err;

    modport master (
        output clk_en, dataA, dataB, printtingScreen, done,
        input  out_dataA, out_dataB, issue, busy, full, empty, count, overflow, timeout_err
    );

    modport slave (
        input  clk_en, dataA, dataB, printtingScreen, done,
        output out_dataA, out_dataB, issue, busy, full, empty, count, overflow, timeout_err
    );
endinterface

// File: rtl/instr_dispatch_scheduler.sv
// instr_dispatch_scheduler: FIFO-buffered custom-instruction dispatcher with sprite-memory blanking gate and done watchdog
module instr_dispatch_scheduler #(
    parameter int         DEPTH      = 8,
    parameter int         PTR_BITS   = $clog2(DEPTH),
    parameter logic [3:0] MEM_OPCODE = 4'b0001,
    parameter int         TIMEOUT    = 255
) (
    input logic clk,
    input logic reset,
    instr_dispatch_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_WINDOW, ISSUE, WAIT_DONE} state_t;

    state_t              state_q, state_d;
    logic [63:0]         mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_BITS:0]   count_q, count_d;
    logic [7:0]          timer_q, timer_d;
    logic [31:0]         out_a_q, out_b_q;
    logic [1:0]          sync_q;
    logic                full_q, empty_q, overflow_q, timeout_q;
    logic                push, pop, timed_out;

    assign push    = bus.clk_en && !full_q;
    assign pop     = state_q == IDLE && !empty_q;
    assign count_d = count_q + (PTR_BITS+1)'(push) - (PTR_BITS+1)'(pop);

    assign bus.out_dataA   = out_a_q;
    assign bus.out_dataB   = out_b_q;
    assign bus.issue       = state_q == ISSUE;
    assign bus.busy        = state_q != IDLE;
    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;

    // Dispatch sequencing: hold memory writes while the print module scans, then watch for done
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timed_out = 1'b0;
        case (state_q)
            IDLE:        state_d = empty_q ? IDLE : WAIT_WINDOW;
            WAIT_WINDOW: state_d = (out_a_q[3:0] == MEM_OPCODE && sync_q[1]) ? WAIT_WINDOW : ISSUE;
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_DONE;
            end
            default: begin
                if (bus.done) begin
                    state_d = IDLE;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
        endcase
    end

    // FIFO storage has no reset; stale entries are unreachable once the pointers clear
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.dataA, bus.dataB};
    end

    // Control state, pointers, flags, synchronizer and the dispatched word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            timer_q    <= '0;
            out_a_q    <= '0;
            out_b_q    <= '0;
            sync_q     <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sync_q     <= {sync_q[0], bus.printtingScreen};
            count_q    <= count_d;
            full_q     <= count_d == (PTR_BITS+1)'(DEPTH);
            empty_q    <= count_d == '0;
            overflow_q <= overflow_q | (bus.clk_en & full_q);
            timeout_q  <= timeout_q | timed_out;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                {out_a_q, out_b_q} <= mem_q[rd_ptr_q];
            end
        end
    end
endmodule

// File: tb/tb_instr_dispatch_scheduler.sv
// tb_instr_dispatch_scheduler: directed stimulus with a scoreboard of expected dispatched words
module tb_instr_dispatch_scheduler;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [63:0] sb [$];

    instr_dispatch_scheduler_if #(.PTR_BITS(3)) bus ();

    instr_dispatch_scheduler #(
        .DEPTH(8), .PTR_BITS(3), .MEM_OPCODE(4'b0001), .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got hang want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit expect_issue);
        bus.clk_en = 1'b1;
        bus.dataA  = a;
        bus.dataB  = b;
        if (expect_issue) sb.push_back({a, b});
        tick();
        bus.clk_en = 1'b0;
    endtask

    task automatic wait_issue(input string nm, input int exp_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.issue && n < 20);
        chk(nm, 64'(n), 64'(exp_n));
    endtask

    task automatic finish_done();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    // Monitor: every issue pulse must match the oldest expected word
    initial forever begin
        @(negedge clk);
        if (bus.issue) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue got %h want none", bus.out_dataA);
            end else begin
                chk("issue_data", {bus.out_dataA, bus.out_dataB}, sb.pop_front());
            end
        end
    end

    initial begin
        int seen;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.clk_en = 1'b0;
        bus.dataA = '0;
        bus.dataB = '0;
        bus.printtingScreen = 1'b0;
        bus.done = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_issue", bus.issue, 0);
        chk("rst_outA", bus.out_dataA, 0);
        chk("rst_flags", {bus.overflow, bus.timeout_err}, 0);
        tick();
        reset = 1'b0;

        push(32'h3fff1, 32'd12, 1);
        chk("t1_count", bus.count, 1);
        chk("t1_empty", bus.empty, 0);
        wait_issue("t1_latency", 2);
        tick();
        tick();
        tick();
        bus.done = 1'b1;
        chk("t1_busy_before", bus.busy, 1);
        tick();
        bus.done = 1'b0;
        chk("t1_busy_after", bus.busy, 0);
        chk("t1_empty_end", bus.empty, 1);
        chk("t1_outA_held", bus.out_dataA, 32'h3fff1);

        bus.printtingScreen = 1'b1;
        tick();
        tick();
        push(32'h0000abc1, 32'd2, 1);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.issue) seen++;
        end
        chk("t2_no_issue", 64'(seen), 0);
        chk("t2_stalled_busy", bus.busy, 1);
        bus.printtingScreen = 1'b0;
        wait_issue("t2_window_lat", 3);
        finish_done();

        bus.printtingScreen = 1'b1;
        tick();
        tick();
        push(32'ha0000001, 32'd0, 1);
        tick();
        for (int i = 1; i <= 9; i++) begin
            push({i[27:0], 4'h1}, i, i <= 8);
            if (i == 8) begin
                chk("t3_count8", bus.count, 8);
                chk("t3_full", bus.full, 1);
                chk("t3_no_ovf_yet", bus.overflow, 0);
            end
        end
        chk("t3_overflow", bus.overflow, 1);
        chk("t3_count_kept", bus.count, 8);
        tick();
        tick();
        chk("t3_ovf_sticky", bus.overflow, 1);
        bus.printtingScreen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wait_issue("t3_drain_lat", i == 0 ? 3 : 2);
            finish_done();
        end
        chk("t3_empty_end", bus.empty, 1);
        chk("t3_ovf_end", bus.overflow, 1);

        push(32'h00000022, 32'h10, 1);
        push(32'h00000033, 32'h11, 1);
        wait_issue("t4_x_lat", 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_no_to_yet", bus.timeout_err, 0);
        chk("t4_busy_wait", bus.busy, 1);
        tick();
        chk("t4_timeout", bus.timeout_err, 1);
        chk("t4_idle", bus.busy, 0);
        wait_issue("t4_y_lat", 2);
        finish_done();
        chk("t4_to_sticky", bus.timeout_err, 1);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_to_cleared", bus.timeout_err, 0);
        push(32'h00000055, 32'h5, 1);
        wait_issue("t5_z_lat", 2);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_busy_last", bus.busy, 1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t5_done_wins", bus.timeout_err, 0);
        chk("t5_idle", bus.busy, 0);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t5_stray_idle", bus.busy, 0);
        push(32'h00000066, 32'h6, 1);
        wait_issue("t5_w_lat", 2);
        tick();
        chk("t5_w_waiting", bus.busy, 1);
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        chk("t5_w_done", bus.busy, 0);
        chk("t5_no_to", bus.timeout_err, 0);

        push(32'h00000077, 32'h7, 1);
        wait_issue("t6_p_lat", 2);
        tick();
        push(32'h00000091, 32'h1, 0);
        push(32'h00000092, 32'h2, 0);
        push(32'h00000093, 32'h3, 0);
        chk("t6_count3", bus.count, 3);
        chk("t6_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_empty", bus.empty, 1);
        chk("t6_rst_outA", bus.out_dataA, 0);
        chk("t6_rst_flags", {bus.issue, bus.full, bus.overflow, bus.timeout_err}, 0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.issue) seen++;
        end
        chk("t6_no_issue", 64'(seen), 0);
        push(32'h00000088, 32'h8, 1);
        wait_issue("t6_r_lat", 2);
        finish_done();
        tick();
        chk("sb_drained", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
